// File: rtl/hlsm_divsel.sv
// rtl/hlsm_divsel.sv - z = (a%b == zero) ? a/b : c/d on one shared restoring divider.
// Optional macro HLSM_DIVZERO_TRAP_EN adds an ERR state that short-circuits zero divisors.
module hlsm_divsel #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] c,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [DATA_WIDTH-1:0] zero,
  output logic [DATA_WIDTH-1:0] z,
  output logic                  Done,
  output logic                  Busy,
  output logic                  DivZero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV_AB,
    S_DIV_CD,
    S_CMP,
    S_SEL
`ifdef HLSM_DIVZERO_TRAP_EN
    , S_ERR
`endif
  } state_t;

  state_t        r_state;
  state_t        w_next;

  // The dividend a lives only in r_quo: it is shifted out as the quotient shifts in.
  logic [W-1:0]  r_b, r_c, r_d, r_zero;
  logic [W-1:0]  r_rem, r_quo, r_dvs;
  logic [W-1:0]  r_e, r_f, r_g;
  logic          r_geqz;
  logic [CW-1:0] r_cnt;

  logic [W:0]    w_shift;
  logic [W-1:0]  w_trial;
  logic          w_ge;
  logic [W-1:0]  w_rem_nx, w_quo_nx;
  logic          w_last;

  assign w_shift  = {r_rem, r_quo[W-1]};
  assign w_ge     = (w_shift >= {1'b0, r_dvs});
  assign w_trial  = w_shift[W-1:0] - r_dvs;
  assign w_rem_nx = w_ge ? w_trial : w_shift[W-1:0];
  assign w_quo_nx = {r_quo[W-2:0], w_ge};
  assign w_last   = (r_cnt == CW'(1));

  assign Busy = (r_state != S_IDLE);

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
`ifdef HLSM_DIVZERO_TRAP_EN
          if ((b == '0) || (d == '0)) w_next = S_ERR;
          else                        w_next = S_DIV_AB;
`else
          w_next = S_DIV_AB;
`endif
        end
      end
      S_DIV_AB: if (w_last) w_next = S_DIV_CD;
      S_DIV_CD: if (w_last) w_next = S_CMP;
      S_CMP:    w_next = S_SEL;
      S_SEL:    w_next = S_IDLE;
`ifdef HLSM_DIVZERO_TRAP_EN
      S_ERR:    w_next = S_IDLE;
`endif
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_zero  <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_e     <= '0;
      r_f     <= '0;
      r_g     <= '0;
      r_geqz  <= 1'b0;
      r_cnt   <= '0;
      z       <= '0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_b     <= b;
            r_c     <= c;
            r_d     <= d;
            r_zero  <= zero;
            r_rem   <= '0;
            r_quo   <= a;
            r_dvs   <= b;
            r_cnt   <= CW'(W);
            DivZero <= 1'b0;
          end
        end
        S_DIV_AB: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_e   <= w_quo_nx;
            r_g   <= w_rem_nx;
            r_rem <= '0;
            r_quo <= r_c;
            r_dvs <= r_d;
            r_cnt <= CW'(W);
          end
        end
        S_DIV_CD: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) r_f <= w_quo_nx;
        end
        S_CMP: r_geqz <= (r_g == r_zero);
        S_SEL: begin
          z       <= r_geqz ? r_e : r_f;
          Done    <= 1'b1;
          DivZero <= (r_b == '0) | (r_d == '0);
        end
`ifdef HLSM_DIVZERO_TRAP_EN
        S_ERR: begin
          z       <= '0;
          Done    <= 1'b1;
          DivZero <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hlsm_divsel.sv
// tb/tb_hlsm_divsel.sv - directed self-checking bench for hlsm_divsel (W=64 and W=8 instances).
// Expectations for zero divisors follow HLSM_DIVZERO_TRAP_EN when it is defined.
module tb_hlsm_divsel;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst, Start;
  logic [63:0] a, b, c, d, zero, z;
  logic        Done, Busy, DivZero;

  logic        Rst8, Start8;
  logic [7:0]  a8, b8, c8, d8, zero8, z8;
  logic        Done8, Busy8, DivZero8;

  int n_cmp  = 0;
  int n_fail = 0;

  hlsm_divsel #(.DATA_WIDTH(64)) dut64 (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .a(a), .b(b), .c(c), .d(d), .zero(zero),
    .z(z), .Done(Done), .Busy(Busy), .DivZero(DivZero)
  );

  hlsm_divsel #(.DATA_WIDTH(8)) dut8 (
    .Clk(Clk), .Rst(Rst8), .Start(Start8),
    .a(a8), .b(b8), .c(c8), .d(d8), .zero(zero8),
    .z(z8), .Done(Done8), .Busy(Busy8), .DivZero(DivZero8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // lat = edge index after which Done is seen (Start sampled at edge 0)
  task automatic run64(input logic [63:0] ia, ib, ic, id, iz, input bit poke,
                       output int lat, output int bcnt, output logic dz0);
    @(negedge Clk);
    a = ia; b = ib; c = ic; d = id; zero = iz; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    dz0 = DivZero;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    lat = 0; bcnt = 0;
    while (!Done && lat < 1000) begin
      if (Busy) bcnt++;
      if (poke && lat == 20) begin
        Start = 1'b1; c = {$urandom, $urandom}; d = 64'd1; zero = {$urandom, $urandom};
      end
      if (poke && lat == 21) Start = 1'b0;
      lat++;
      @(negedge Clk);
    end
  endtask

  int   lat, bcnt, seen, n8, first8, second8;
  logic dz0;
  logic [7:0] zfirst8;

  initial begin
    Rst = 1'b1; Start = 1'b0; a = '0; b = '0; c = '0; d = '0; zero = '0;
    Rst8 = 1'b1; Start8 = 1'b0; a8 = '0; b8 = '0; c8 = '0; d8 = '0; zero8 = '0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0; Rst8 = 1'b0;
    check("rst_z", z, 64'd0);
    check("rst_done", Done, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_divzero", DivZero, 1'b0);
    check("rst_busy8", Busy8, 1'b0);

    // g = 2 matches zero = 2 -> z = 100/7
    run64(64'd100, 64'd7, 64'd50, 64'd5, 64'd2, 1'b0, lat, bcnt, dz0);
    check("t1_z", z, 64'd14);
    check("t1_latency", lat, 130);
    check("t1_busy_cycles", bcnt, 130);
    check("t1_divzero", DivZero, 1'b0);
    check("t1_busy_at_done", Busy, 1'b0);
    @(negedge Clk);
    check("t1_done_pulse", Done, 1'b0);

    // g = 2 vs zero = 0 -> z = 50/5; Start and input churn during Busy is ignored
    run64(64'd100, 64'd7, 64'd50, 64'd5, 64'd0, 1'b1, lat, bcnt, dz0);
    check("t2_z", z, 64'd10);
    check("t2_latency", lat, 130);

    run64(64'd100, 64'd0, 64'd9, 64'd3, 64'd100, 1'b0, lat, bcnt, dz0);
`ifdef HLSM_DIVZERO_TRAP_EN
    check("t3_z", z, 64'd0);
    check("t3_latency", lat, 1);
`else
    check("t3_z", z, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3_latency", lat, 130);
`endif
    check("t3_divzero", DivZero, 1'b1);

    run64(64'd9, 64'd3, 64'd1, 64'd1, 64'd0, 1'b0, lat, bcnt, dz0);
    check("t4_divzero_cleared_at_start", dz0, 1'b0);
    check("t4_z", z, 64'd3);
    check("t4_latency", lat, 130);
    check("t4_divzero", DivZero, 1'b0);

    // Reset 40 cycles into an operation
    @(negedge Clk);
    a = 64'd100; b = 64'd7; c = 64'd50; d = 64'd5; zero = 64'd2; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (40) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("t5_busy", Busy, 1'b0);
    check("t5_done", Done, 1'b0);
    check("t5_z", z, 64'd0);
    check("t5_divzero", DivZero, 1'b0);
    seen = 0;
    repeat (200) begin
      @(negedge Clk);
      if (Done) seen++;
    end
    check("t5_no_done_after_abort", seen, 0);
    run64(64'd100, 64'd7, 64'd50, 64'd5, 64'd2, 1'b0, lat, bcnt, dz0);
    check("t5_z_after", z, 64'd14);
    check("t5_latency_after", lat, 130);

    // W = 8, Start held high: back-to-back operations every 2W+3 = 19 cycles
    @(negedge Clk);
    a8 = 8'd255; b8 = 8'd16; c8 = 8'd200; d8 = 8'd10; zero8 = 8'd15; Start8 = 1'b1;
    @(negedge Clk);
    n8 = 0; first8 = -1; second8 = -1; zfirst8 = '0;
    while (second8 < 0 && n8 < 100) begin
      if (Done8) begin
        if (first8 < 0) begin
          first8 = n8;
          zfirst8 = z8;
        end else begin
          second8 = n8;
        end
      end
      n8++;
      @(negedge Clk);
    end
    Start8 = 1'b0;
    check("t6_first_done", first8, 18);
    check("t6_z_first", zfirst8, 8'd15);
    check("t6_second_done", second8, 37);
    check("t6_z_second", z8, 8'd15);
    check("t6_divzero", DivZero8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hlsm_divsel.md
# hlsm_divsel

Parametrised, multi-cycle successor to the fixed-width divide/select HLSM.
- Computes e = a / b, f = c / d and g = a % b on one shared iterative restoring divider, one quotient bit per cycle.
- Result: z = (g == zero) ? e : f, under a Start/Done handshake.
- Sits in the HLS datapath library as the area-optimised replacement for the single-cycle combinational divide version, adding Busy and divide-by-zero reporting.

## Interface
- DATA_WIDTH, 64, width of all operands and the result; unsigned; must be >= 2.
- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Start  in  1  operation request; sampled only in IDLE.
- a, b, c, d  in  DATA_WIDTH  dividends a and c, divisors b and d.
- zero  in  DATA_WIDTH  comparison value for the remainder g.
- z  out  DATA_WIDTH  result register; holds its value until the next SEL write.
- Done  out  1  single-cycle pulse: z is valid.
- Busy  out  1  high in every state except IDLE.
- DivZero  out  1  set with Done when b == 0 or d == 0; cleared at the next accepted Start.

## Operation
- States: IDLE, DIV_AB, DIV_CD, CMP, SEL, plus ERR, which exists only with the trap macro.
- IDLE, Start = 1:
  - latch a, b, c, d and zero into internal registers;
  - load the divider with a / b and set the bit counter to DATA_WIDTH;
  - clear DivZero; go to DIV_AB.
- IDLE, Start = 0: stay in IDLE.
- DIV_AB:
  - each edge: shift the remainder left, bring in the next dividend MSB, trial-subtract, set the quotient bit, decrement the counter;
  - on the last iteration: store e = quotient, g = remainder, reload the divider with c / d, go to DIV_CD.
- DIV_CD: same iteration. On the last iteration, store f = quotient and go to CMP.
- CMP: register gEQz = (g == zero); go to SEL.
- SEL:
  - z <= gEQz ? e : f, Done <= 1;
  - DivZero <= (b_reg == 0) | (d_reg == 0);
  - go to IDLE.
- Done is deasserted on the following edge.
- Divide by zero without the trap: no special casing. The restoring algorithm naturally yields quotient = all ones and remainder = dividend; the result is delivered normally.
- Inputs may change freely after the Start edge; only latched copies are used.
- Start while Busy = 1 is ignored, not queued.
- Arithmetic is unsigned throughout. The trial subtract is DATA_WIDTH+1 bits wide; no overflow is possible.

## Timing
- Reset values (synchronous Rst): state IDLE, z = 0, Done = 0, Busy = 0, DivZero = 0; internal counter and operand registers cleared.
- Rst mid-operation aborts at that edge with the reset values above. No Done is issued for the aborted operation.
- Rst has priority over Start on the same edge.
- Normal latency:
  - Start sampled at edge 0; DIV_AB at edges 1..W, DIV_CD at edges W+1..2W, CMP at edge 2W+1, SEL at edge 2W+2.
  - Done is high for the cycle after edge 2W+2, where W = DATA_WIDTH; this is 130 cycles at W = 64.
- Busy rises after edge 0 and falls after edge 2W+2; it is low in the same cycle that Done is high.
- With Start held high, the next operation is accepted at edge 2W+3, giving a throughput of one result per 2W+3 cycles.

## Configuration
- HLSM_DIVZERO_TRAP_EN defined:
  - if the latched b == 0 or d == 0 at edge 0, go to ERR instead of DIV_AB;
  - at edge 1, ERR sets z <= 0, Done <= 1, DivZero <= 1 and returns to IDLE.
  - Done is high 2 cycles after Start (after edge 1).
- HLSM_DIVZERO_TRAP_EN not defined:
  - the ERR state and its logic are absent;
  - zero divisors run the full 2W+3-cycle schedule with the natural all-ones/dividend result;
  - DivZero is still reported at SEL.

## Test plan
- W=64, a=100, b=7, c=50, d=5, zero=2 -> g=2 matches, z=14, Done pulse one cycle after edge 130, DivZero=0, Busy high for exactly 130 cycles.
- Same operands, zero=0 -> g=2 does not match, z=10.
- No macro, W=64, a=100, b=0, c=9, d=3, zero=100 -> g=100 matches, z=64'hFFFF_FFFF_FFFF_FFFF, DivZero=1, latency 130.
- Macro defined, b=0 (any other operands) -> Done one cycle after edge 1, z=0, DivZero=1. A following valid op a=9, b=3, c=1, d=1, zero=0 -> z=3, DivZero=0.
- Rst asserted at cycle 40 of an operation -> Busy, Done, z, DivZero all 0 on the next cycle, no Done is issued. A Start pulse with W=64, a=100, b=7, c=50, d=5, zero=2 then yields z=14 at full 130-cycle latency.
- W=8, Start held high, a=255, b=16, c=200, d=10, zero=15 -> z=15 with Done one cycle after edge 18; a second Done pulse one cycle after edge 37; Start pulses during Busy ignored.
